// File: rtl/bs_encoder.sv
// bs_encoder -- transmit-side USB bit stuffer.
//
// Takes the serial packet stream (PID, data, CRC) one bit per cycle and
// inserts a 0 after every STUFF_LEN consecutive 1s. While a stuff bit is
// being inserted, upstream is held off for one cycle via 'pause'. The
// stuffed stream goes to the NRZI encoder with start/end framing pulses.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           asynchronous active-high reset
//   start_encode  one-cycle pulse with the first packet bit on s_in
//   s_in          packet data bit (held by upstream while pause=1)
//   end_encode    high with the last packet bit (held while pause=1)
//   pause         combinational; current s_in/end_encode not consumed
//   s_out         stuffed serial bit (registered)
//   out_valid     s_out carries a packet bit this cycle
//   start_nrzi    one-cycle pulse with the first output bit
//   end_nrzi      one-cycle pulse with the final output bit
//   stuff_count   stuff bits inserted in current/last packet (saturating)

module bs_encoder #(
   parameter int STUFF_LEN = 6,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_encode,
   input  logic             s_in,
   input  logic             end_encode,
   output logic             pause,
   output logic             s_out,
   output logic             out_valid,
   output logic             start_nrzi,
   output logic             end_nrzi,
   output logic [CNT_W-1:0] stuff_count
);

   localparam int            OW       = $clog2(STUFF_LEN + 1);
   localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);

   typedef enum logic [1:0] {IDLE, SEND, TAIL} state_t;

   state_t           state_q, state_d;
   logic [OW-1:0]    ones_cnt_q, ones_cnt_d;
   logic             s_out_q, s_out_d;
   logic             out_valid_q, out_valid_d;
   logic             start_nrzi_q, start_nrzi_d;
   logic             end_nrzi_q, end_nrzi_d;
   logic [CNT_W-1:0] stuff_count_q, stuff_count_d;
   logic             take;          // an upstream bit is consumed this cycle
   logic [CNT_W-1:0] stuff_inc;     // saturating increment of stuff_count

   assign stuff_inc = (stuff_count_q == {CNT_W{1'b1}}) ? stuff_count_q
                                                        : stuff_count_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      ones_cnt_d    = ones_cnt_q;
      s_out_d       = 1'b0;
      out_valid_d   = 1'b0;
      start_nrzi_d  = 1'b0;
      end_nrzi_d    = 1'b0;
      stuff_count_d = stuff_count_q;
      pause         = 1'b0;
      take          = 1'b0;

      case (state_q)
         IDLE: begin
            // end_encode alone is ignored; stuff_count holds until a new start
            if (start_encode) begin
               take          = 1'b1;
               stuff_count_d = '0;
               start_nrzi_d  = 1'b1;
               out_valid_d   = 1'b1;
               s_out_d       = s_in;
               ones_cnt_d    = s_in ? OW'(1) : '0;
            end
         end
         SEND: begin
            if (ones_cnt_q == ONES_MAX) begin
               // Insert the stuff bit and stall upstream for this cycle.
               pause         = 1'b1;
               out_valid_d   = 1'b1;
               s_out_d       = 1'b0;
               ones_cnt_d    = '0;
               stuff_count_d = stuff_inc;
            end else begin
               take        = 1'b1;
               out_valid_d = 1'b1;
               s_out_d     = s_in;
               ones_cnt_d  = s_in ? ones_cnt_q + 1'b1 : '0;
            end
         end
         TAIL: begin
            // Trailing stuff bit after a packet that ended on a full run.
            out_valid_d   = 1'b1;
            s_out_d       = 1'b0;
            end_nrzi_d    = 1'b1;
            ones_cnt_d    = '0;
            stuff_count_d = stuff_inc;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // End-of-packet handling for the bit just consumed. A packet whose
      // last bit completes a run still owes a stuff bit, so end_nrzi moves
      // to the TAIL cycle.
      if (take) begin
         if (end_encode) begin
            if (ones_cnt_d == ONES_MAX) begin
               state_d = TAIL;
            end else begin
               end_nrzi_d = 1'b1;
               state_d    = IDLE;
            end
         end else begin
            state_d = SEND;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         ones_cnt_q    <= '0;
         s_out_q       <= 1'b0;
         out_valid_q   <= 1'b0;
         start_nrzi_q  <= 1'b0;
         end_nrzi_q    <= 1'b0;
         stuff_count_q <= '0;
      end else begin
         state_q       <= state_d;
         ones_cnt_q    <= ones_cnt_d;
         s_out_q       <= s_out_d;
         out_valid_q   <= out_valid_d;
         start_nrzi_q  <= start_nrzi_d;
         end_nrzi_q    <= end_nrzi_d;
         stuff_count_q <= stuff_count_d;
      end
   end

   assign s_out       = s_out_q;
   assign out_valid   = out_valid_q;
   assign start_nrzi  = start_nrzi_q;
   assign end_nrzi    = end_nrzi_q;
   assign stuff_count = stuff_count_q;

endmodule

// File: tb/tb_bs_encoder.sv
// Testbench for bs_encoder: drives packets (directed and $urandom) and
// compares the stuffed stream, framing pulses, pause cycles and stuff
// counts against a bit-list reference model.
`timescale 1ns/1ps

module tb_bs_encoder;

   localparam int STUFF_LEN = 6;
   localparam int CNT_W     = 8;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_encode = 1'b0;
   logic             s_in = 1'b0;
   logic             end_encode = 1'b0;
   logic             pause;
   logic             s_out;
   logic             out_valid;
   logic             start_nrzi;
   logic             end_nrzi;
   logic [CNT_W-1:0] stuff_count;

   bs_encoder #(.STUFF_LEN(STUFF_LEN), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_encode (start_encode),
      .s_in         (s_in),
      .end_encode   (end_encode),
      .pause        (pause),
      .s_out        (s_out),
      .out_valid    (out_valid),
      .start_nrzi   (start_nrzi),
      .end_nrzi     (end_nrzi),
      .stuff_count  (stuff_count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Packets queued for the next stream
   bit pk_bits[$];
   bit pk_xs[$];     // stray start_encode on a non-first bit (must be ignored)
   int pk_len[$];

   // Reference model outputs
   bit exp_bits[$];
   bit exp_st[$];
   bit exp_en[$];
   int exp_cnt[$];
   int exp_pauses;

   function automatic void clear_packets();
      pk_bits.delete();
      pk_xs.delete();
      pk_len.delete();
   endfunction

   function automatic void add_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         pk_bits.push_back(s.getc(i) == "1");
         pk_xs.push_back(1'b0);
      end
      pk_len.push_back(s.len());
   endfunction

   function automatic void add_rand(input int len, input bit stray);
      for (int i = 0; i < len; i++) begin
         pk_bits.push_back($urandom_range(3, 0) != 0);
         pk_xs.push_back(stray && (i != 0) && ($urandom_range(7, 0) == 0));
      end
      pk_len.push_back(len);
   endfunction

   function automatic void add_ones(input int len);
      for (int i = 0; i < len; i++) begin
         pk_bits.push_back(1'b1);
         pk_xs.push_back(1'b0);
      end
      pk_len.push_back(len);
   endfunction

   // Model: copy each packet bit, append a 0 after every STUFF_LEN ones in a
   // row (run restarts per packet). Stuff bits not after the final bit cost
   // one upstream pause each.
   function automatic void build_model();
      int base = 0;
      exp_bits.delete();
      exp_st.delete();
      exp_en.delete();
      exp_cnt.delete();
      exp_pauses = 0;
      foreach (pk_len[p]) begin
         int ones   = 0;
         int stuffs = 0;
         int first  = exp_bits.size();
         for (int i = 0; i < pk_len[p]; i++) begin
            bit b;
            b = pk_bits[base + i];
            exp_bits.push_back(b);
            exp_st.push_back(1'b0);
            exp_en.push_back(1'b0);
            ones = b ? ones + 1 : 0;
            if (ones == STUFF_LEN) begin
               exp_bits.push_back(1'b0);
               exp_st.push_back(1'b0);
               exp_en.push_back(1'b0);
               ones = 0;
               stuffs++;
               if (i != pk_len[p] - 1) exp_pauses++;
            end
         end
         exp_st[first] = 1'b1;
         exp_en[exp_en.size() - 1] = 1'b1;
         exp_cnt.push_back(stuffs > CNT_MAX ? CNT_MAX : stuffs);
         base += pk_len[p];
      end
   endfunction

   // Streams all queued packets, starting each one in the cycle its
   // predecessor's end_nrzi is visible, so output must be gap-free.
   task automatic run_stream(input string name);
      int pi = 0, bi = 0, base = 0, k = 0, pauses = 0, cyc = 0, limit;
      bit waiting = 1'b0, done = 1'b0, p;
      build_model();
      limit = exp_bits.size() + 20;
      while (!done) begin
         if (!waiting) begin
            s_in         = pk_bits[base + bi];
            start_encode = (bi == 0) || pk_xs[base + bi];
            end_encode   = (bi == pk_len[pi] - 1);
         end else begin
            s_in         = 1'($urandom_range(1, 0));
            start_encode = 1'b0;
            end_encode   = 1'b0;
         end
         #1;
         p = pause;
         if (p) pauses++;
         @(posedge clk);
         #1;
         cyc++;
         vectors++;
         if (k < exp_bits.size()) begin
            if (out_valid !== 1'b1 || s_out !== exp_bits[k] ||
                start_nrzi !== exp_st[k] || end_nrzi !== exp_en[k]) begin
               errors++;
               $display("FAIL %s out[%0d]: got v=%b s=%b st=%b en=%b, expected v=1 s=%b st=%b en=%b",
                        name, k, out_valid, s_out, start_nrzi, end_nrzi,
                        exp_bits[k], exp_st[k], exp_en[k]);
            end
            k++;
         end else if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s extra output bit: got out_valid=%b, expected 0", name, out_valid);
         end
         if (!waiting && !p) begin
            bi++;
            if (bi == pk_len[pi]) waiting = 1'b1;
         end
         if (waiting && end_nrzi === 1'b1) begin
            vectors++;
            if (stuff_count !== CNT_W'(exp_cnt[pi])) begin
               errors++;
               $display("FAIL %s stuff_count pkt %0d: got %0d, expected %0d",
                        name, pi, stuff_count, exp_cnt[pi]);
            end
            base += pk_len[pi];
            pi++;
            bi = 0;
            waiting = 1'b0;
            if (pi == pk_len.size()) done = 1'b1;
         end
         if (!done && cyc > limit) begin
            errors++;
            $display("FAIL %s timeout: got %0d packets done, expected %0d", name, pi, pk_len.size());
            done = 1'b1;
         end
      end
      start_encode = 1'b0;
      end_encode   = 1'b0;
      s_in         = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || k != exp_bits.size() || pauses != exp_pauses) begin
         errors++;
         $display("FAIL %s wrap-up: got out_valid=%b bits=%0d pauses=%0d, expected 0 bits=%0d pauses=%0d",
                  name, out_valid, k, pauses, exp_bits.size(), exp_pauses);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({pause, s_out, out_valid, start_nrzi, end_nrzi, stuff_count} !== '0) begin
         errors++;
         $display("FAIL reset_state: got p=%b s=%b v=%b st=%b en=%b cnt=%0d, expected all 0",
                  pause, s_out, out_valid, start_nrzi, end_nrzi, stuff_count);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      clear_packets(); add_str("11000011");      run_stream("pid");
      clear_packets(); add_str("11111110");      run_stream("seven_ones");
      clear_packets(); add_str("111111111111");  run_stream("twelve_ones_tail");
      clear_packets(); add_str("1111101111110"); run_stream("run_restart");
   endtask

   task automatic test_idle_end_ignored();
      int held;
      held = exp_cnt[exp_cnt.size() - 1];
      for (int i = 0; i < 4; i++) begin
         end_encode = 1'b1;
         s_in       = 1'($urandom_range(1, 0));
         @(posedge clk);
         #1;
         vectors++;
         if (out_valid !== 1'b0 || end_nrzi !== 1'b0 || pause !== 1'b0 ||
             stuff_count !== CNT_W'(held)) begin
            errors++;
            $display("FAIL idle_end_ignored: got v=%b en=%b p=%b cnt=%0d, expected 0 0 0 cnt=%0d",
                     out_valid, end_nrzi, pause, stuff_count, held);
         end
      end
      end_encode = 1'b0;
   endtask

   task automatic test_reset_mid_packet();
      start_encode = 1'b1;
      s_in         = 1'b1;
      end_encode   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         start_encode = 1'b0;
      end
      vectors++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_valid: got %b, expected 1", out_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({out_valid, end_nrzi, pause, stuff_count, start_nrzi, s_out} !== '0) begin
         errors++;
         $display("FAIL reset_mid_packet: got v=%b en=%b p=%b cnt=%0d st=%b s=%b, expected all 0",
                  out_valid, end_nrzi, pause, stuff_count, start_nrzi, s_out);
      end
      @(negedge clk);
      rst  = 1'b0;
      s_in = 1'b0;
      clear_packets(); add_str("1110000111111000"); run_stream("after_reset");
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         clear_packets();
         add_rand($urandom_range(40, 1), 1'b1);
         run_stream("random_single");
         repeat ($urandom_range(3, 0)) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      clear_packets();
      add_str("11000011");
      add_str("10100101");
      run_stream("b2b_plan");
      clear_packets();
      for (int n = 0; n < 6; n++) add_rand($urandom_range(30, 1), 1'b1);
      run_stream("b2b_random");
      clear_packets();
      add_str("1111111");
      add_str("111111");
      add_str("1");
      run_stream("b2b_tails");
   endtask

   task automatic test_saturation();
      clear_packets();
      add_ones(1600);
      run_stream("saturation");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_idle_end_ignored();
      test_reset_mid_packet();
      test_random();
      test_back_to_back();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
